// File: rtl/pdm_stereo_modulator_pkg.sv
// Shared audio definitions for the stereo PDM modulator.
//   PCM_W / I1_W / I2_W : sample and integrator widths (two's complement)
//   FB_MAG              : feedback magnitude, +/- full scale of a PCM sample
//   saturate()          : clamp a wide signed sum to an n-bit signed range
//   scale_7_8()         : 7/8 full-scale input attenuation for loop stability
package pdm_stereo_modulator_pkg;

    localparam int PCM_W    = 16;
    localparam int I1_W     = 20;
    localparam int I2_W     = 24;
    localparam int FB_MAG   = 32768;
    localparam int SAT_IN_W = I2_W + 2;

    typedef logic signed [PCM_W-1:0] pcm_t;

    typedef struct packed {
        pcm_t left;
        pcm_t right;
    } pcm_pair_t;

    // Result stays SAT_IN_W wide; callers truncate to n bits, which is
    // lossless because the value is already inside the n-bit range.
    function automatic logic signed [SAT_IN_W-1:0] saturate(
        input logic signed [SAT_IN_W-1:0] v,
        input int unsigned                n
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        hi = (SAT_IN_W'(1) <<< (n - 1)) - SAT_IN_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // s - s/8 cannot overflow 16 bits: range is [-28672, 28672].
    function automatic pcm_t scale_7_8(input pcm_t s);
        return s - (s >>> 3);
    endfunction

endpackage

// File: rtl/pdm_stereo_modulator_dsm2.sv
// Single-channel second-order delta-sigma modulator.
//   clk48m   : system clock
//   rst_n    : synchronous active-low reset
//   bit_tick : advance the loop by one PDM bit
//   x        : scaled signed input sample (0 when muted)
//   pdm      : registered 1-bit output, updated on bit_tick
module pdm_dsm2
    import pdm_stereo_modulator_pkg::*;
(
    input  logic             clk48m,
    input  logic             rst_n,
    input  logic             bit_tick,
    input  logic signed [PCM_W-1:0] x,
    output logic             pdm
);

    localparam logic signed [PCM_W+1:0] FB_POS = (PCM_W+2)'(FB_MAG);
    localparam logic signed [PCM_W+1:0] FB_NEG = -FB_POS;

    logic signed [I1_W-1:0]     i1;
    logic signed [I2_W-1:0]     i2;
    logic                       y;
    logic signed [PCM_W+1:0]    fb;
    logic signed [I1_W+1:0]     sum1;
    logic signed [I2_W+1:0]     sum2;
    logic signed [SAT_IN_W-1:0] sat1;
    logic signed [SAT_IN_W-1:0] sat2;

    always_comb begin
        y    = ~i2[I2_W-1];
        fb   = y ? FB_POS : FB_NEG;
        sum1 = (I1_W+2)'(i1) + (I1_W+2)'(x) - (I1_W+2)'(fb);
        // Second integrator consumes the pre-update value of i1.
        sum2 = (I2_W+2)'(i2) + (I2_W+2)'(i1) - (I2_W+2)'(fb);
        sat1 = saturate(SAT_IN_W'(sum1), I1_W);
        sat2 = saturate(SAT_IN_W'(sum2), I2_W);
    end

    always_ff @(posedge clk48m) begin
        if (!rst_n) begin
            i1  <= '0;
            i2  <= '0;
            pdm <= 1'b0;
        end else if (bit_tick) begin
            i1  <= I1_W'(sat1);
            i2  <= I2_W'(sat2);
            pdm <= y;
        end
    end

endmodule

// File: rtl/pdm_stereo_modulator.sv
// Stereo second-order PDM modulator: bit/sample tick generation, one-deep
// sample holding register with valid/ready handshake, and two lockstep
// single-channel modulators.
//   clk48m      : system clock
//   rst_n       : synchronous active-low reset
//   s_left      : signed left PCM sample
//   s_right     : signed right PCM sample
//   s_valid     : sample pair valid
//   s_ready     : holding register empty
//   mute        : force modulator input to zero
//   pdm_l/pdm_r : PDM output bits
//   sample_tick : pulse at each sample boundary
//   underrun    : pulse when a sample boundary finds the holding register empty
module pdm_stereo_modulator
    import pdm_stereo_modulator_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned OSR     = 64
) (
    input  logic                    clk48m,
    input  logic                    rst_n,
    input  logic signed [PCM_W-1:0] s_left,
    input  logic signed [PCM_W-1:0] s_right,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    mute,
    output logic                    pdm_l,
    output logic                    pdm_r,
    output logic                    sample_tick,
    output logic                    underrun
);

    localparam int BIT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SMP_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic [BIT_W-1:0] bit_cnt;
    logic [SMP_W-1:0] smp_cnt;
    logic             bit_tick;
    logic             hold_full;
    logic             transfer;
    pcm_pair_t        hold;
    pcm_pair_t        active;
    pcm_pair_t        cur;
    pcm_t             x_l;
    pcm_t             x_r;

    always_comb begin
        bit_tick    = (bit_cnt == BIT_W'(CLK_DIV - 1));
        sample_tick = bit_tick && (smp_cnt == SMP_W'(OSR - 1));
        underrun    = sample_tick && !hold_full;
        s_ready     = !hold_full;
        transfer    = s_valid && !hold_full;
        // A sample promoted at this boundary already feeds this bit's update.
        cur         = (sample_tick && hold_full) ? hold : active;
        x_l         = mute ? '0 : scale_7_8(cur.left);
        x_r         = mute ? '0 : scale_7_8(cur.right);
    end

    always_ff @(posedge clk48m) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            smp_cnt   <= '0;
            hold_full <= 1'b0;
            hold      <= '0;
            active    <= '0;
        end else begin
            bit_cnt <= bit_tick ? '0 : bit_cnt + BIT_W'(1);
            if (bit_tick) begin
                smp_cnt <= (smp_cnt == SMP_W'(OSR - 1)) ? '0 : smp_cnt + SMP_W'(1);
            end
            if (sample_tick && hold_full) begin
                active    <= hold;
                hold_full <= 1'b0;
            end
            // transfer requires an empty hold, so it never collides with
            // the promotion above.
            if (transfer) begin
                hold      <= '{left: s_left, right: s_right};
                hold_full <= 1'b1;
            end
        end
    end

    pdm_dsm2 u_dsm_l (
        .clk48m   (clk48m),
        .rst_n    (rst_n),
        .bit_tick (bit_tick),
        .x        (x_l),
        .pdm      (pdm_l)
    );

    pdm_dsm2 u_dsm_r (
        .clk48m   (clk48m),
        .rst_n    (rst_n),
        .bit_tick (bit_tick),
        .x        (x_r),
        .pdm      (pdm_r)
    );

endmodule

// File: tb/tb_pdm_stereo_modulator.sv
module tb_pdm_stereo_modulator;

    localparam int CLK_DIV = 16;
    localparam int OSR     = 64;

    logic               clk48m;
    logic               rst_n;
    logic signed [15:0] s_left;
    logic signed [15:0] s_right;
    logic               s_valid;
    logic               s_ready;
    logic               mute;
    logic               pdm_l;
    logic               pdm_r;
    logic               sample_tick;
    logic               underrun;

    pdm_stereo_modulator #(.CLK_DIV(CLK_DIV), .OSR(OSR)) u_dut (
        .clk48m      (clk48m),
        .rst_n       (rst_n),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .mute        (mute),
        .pdm_l       (pdm_l),
        .pdm_r       (pdm_r),
        .sample_tick (sample_tick),
        .underrun    (underrun)
    );

    initial begin
        clk48m = 1'b0;
        forever #5 clk48m = ~clk48m;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the loop equations.
    longint m_i1[2];
    longint m_i2[2];
    int     m_pdm[2];
    int     m_act[2];
    int     m_hold[2];
    bit     m_full;
    int     m_cc;
    int     m_sc;

    function automatic longint clamp(input longint v, input int bits);
        longint hi;
        longint lo;
        hi = (longint'(1) << (bits - 1)) - 1;
        lo = -(longint'(1) << (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_step(input bit bt, input bit st);
        int     cur[2];
        int     inp[2];
        longint x;
        longint fb;
        bit     xfer;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_i1[c] = 0; m_i2[c] = 0; m_pdm[c] = 0; m_act[c] = 0; m_hold[c] = 0;
            end
            m_full = 0; m_cc = 0; m_sc = 0;
            return;
        end
        inp[0] = int'(s_left);
        inp[1] = int'(s_right);
        xfer = s_valid && !m_full;
        for (int c = 0; c < 2; c++) cur[c] = (st && m_full) ? m_hold[c] : m_act[c];
        if (bt) begin
            for (int c = 0; c < 2; c++) begin
                x  = mute ? 0 : longint'(cur[c] - (cur[c] >>> 3));
                fb = (m_i2[c] >= 0) ? 32768 : -32768;
                m_pdm[c] = (m_i2[c] >= 0) ? 1 : 0;
                m_i2[c]  = clamp(m_i2[c] + m_i1[c] - fb, 24);
                m_i1[c]  = clamp(m_i1[c] + x - fb, 20);
            end
        end
        if (st && m_full) begin
            m_act[0] = m_hold[0]; m_act[1] = m_hold[1]; m_full = 0;
        end
        if (xfer) begin
            m_hold[0] = inp[0]; m_hold[1] = inp[1]; m_full = 1;
        end
        if (bt) m_sc = (m_sc == OSR - 1) ? 0 : m_sc + 1;
        m_cc = bt ? 0 : m_cc + 1;
    endtask

    bit check_en = 0;
    bit prev_bt  = 0;
    int nbits    = 0;
    int ones_l   = 0;
    int ones_r   = 0;
    int n_stick  = 0;
    int n_under  = 0;
    int n_ready  = 0;
    int bitlog[$];

    // One clock: compare DUT to model, record bits, advance model, step clock.
    // Called and returns at a negedge.
    task automatic cycle();
        bit bt;
        bit st;
        bt = (m_cc == CLK_DIV - 1);
        st = bt && (m_sc == OSR - 1);
        if (check_en) begin
            check("pdm_l", pdm_l, m_pdm[0]);
            check("pdm_r", pdm_r, m_pdm[1]);
            check("s_ready", s_ready, !m_full);
            check("sample_tick", sample_tick, st);
            check("underrun", underrun, st && !m_full);
        end
        if (prev_bt) begin
            nbits++;
            ones_l += int'(pdm_l);
            ones_r += int'(pdm_r);
            bitlog.push_back(int'(pdm_l));
        end
        n_stick += int'(sample_tick);
        n_under += int'(underrun);
        n_ready += int'(s_ready);
        model_step(bt, st);
        prev_bt = rst_n && bt;
        @(posedge clk48m);
        @(negedge clk48m);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        mute    = 1'b0;
        s_left  = '0;
        s_right = '0;
        cycle();
        cycle();
        rst_n    = 1'b1;
        check_en = 1;
        bitlog.delete();
        nbits = 0; ones_l = 0; ones_r = 0;
    endtask

    task automatic run_bits(input int n);
        int start;
        int guard;
        start = nbits;
        guard = 0;
        while (nbits - start < n && guard < (n + 2) * CLK_DIV) begin
            cycle();
            guard++;
        end
        if (nbits - start < n) check("run_bits timeout", nbits - start, n);
    endtask

    task automatic run_ticks(input int n);
        int start;
        int guard;
        start = n_stick;
        guard = 0;
        while (n_stick - start < n && guard < (n + 1) * CLK_DIV * OSR) begin
            cycle();
            guard++;
        end
        if (n_stick - start < n) check("run_ticks timeout", n_stick - start, n);
    endtask

    typedef struct {
        int sample;
        bit mute;
        int exp_ones;
    } row_t;

    row_t rows[4];
    int   pat[4];

    initial begin
        // Expected ones per 512 bits = 512 * (x + 32768) / 65536, x = s - s/8.
        rows[0] = '{sample:  16384, mute: 1'b0, exp_ones: 368};
        rows[1] = '{sample: -32768, mute: 1'b0, exp_ones:  32};
        rows[2] = '{sample:  20000, mute: 1'b1, exp_ones: 256};
        rows[3] = '{sample: -16384, mute: 1'b0, exp_ones: 144};
        pat = '{1, 0, 0, 1};

        rst_n = 1'b0; s_valid = 1'b0; mute = 1'b0; s_left = '0; s_right = '0;
        @(negedge clk48m);

        // Reset state and zero-input limit cycle.
        do_reset();
        check("reset s_ready", s_ready, 1);
        check("reset pdm_l", pdm_l, 0);
        check("reset pdm_r", pdm_r, 0);
        check("reset sample_tick", sample_tick, 0);
        check("reset underrun", underrun, 0);
        check("reset i1_l", u_dut.u_dsm_l.i1, 0);
        check("reset i2_l", u_dut.u_dsm_l.i2, 0);
        run_bits(64);
        for (int k = 0; k < 8; k++) check($sformatf("zero pattern bit%0d", k), bitlog[k], pat[k % 4]);
        check("zero ones per 64", ones_l, 32);

        // Table-driven DC density.
        foreach (rows[r]) begin
            do_reset();
            s_left  = 16'(rows[r].sample);
            s_right = 16'(rows[r].sample);
            s_valid = 1'b1;
            mute    = rows[r].mute;
            run_bits(128);
            ones_l = 0; ones_r = 0;
            run_bits(512);
            check_range($sformatf("density_l row%0d", r), ones_l, rows[r].exp_ones - 2, rows[r].exp_ones + 2);
            check_range($sformatf("density_r row%0d", r), ones_r, rows[r].exp_ones - 2, rows[r].exp_ones + 2);
            check_range($sformatf("i1 bound row%0d", r), u_dut.u_dsm_l.i1, -524288, 524287);
        end
        mute = 1'b0;

        // Handshake with s_valid held: one acceptance per sample period.
        do_reset();
        s_valid = 1'b1;
        s_left  = 16'($urandom);
        s_right = 16'($urandom);
        cycle();
        n_ready = 0; n_under = 0;
        for (int i = 0; i < 2 * CLK_DIV * OSR; i++) begin
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            cycle();
        end
        check("ready pulses per 2048", n_ready, 2);
        check("no underrun while fed", n_under, 0);

        // Underrun after a single pair, then recovery.
        do_reset();
        s_valid = 1'b1; s_left = 16'sd12000; s_right = -16'sd9000;
        cycle();
        s_valid = 1'b0;
        n_under = 0;
        run_ticks(4);
        check("underrun count", n_under, 3);
        s_valid = 1'b1; s_left = -16'sd20000; s_right = 16'sd5000;
        cycle();
        s_valid = 1'b0;
        n_under = 0;
        run_ticks(1);
        check("underrun cleared", n_under, 0);
        n_under = 0;
        run_ticks(1);
        check("underrun again", n_under, 1);

        // Mid-stream reset.
        do_reset();
        s_valid = 1'b1; s_left = 16'sd16384; s_right = 16'sd16384;
        run_ticks(3);
        run_bits(5);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        s_valid = 1'b0;
        check("midreset pdm_l", pdm_l, 0);
        check("midreset s_ready", s_ready, 1);
        check("midreset i1_l", u_dut.u_dsm_l.i1, 0);
        check("midreset i2_l", u_dut.u_dsm_l.i2, 0);
        check("midreset i1_r", u_dut.u_dsm_r.i1, 0);
        bitlog.delete();
        run_bits(8);
        for (int k = 0; k < 8; k++) check($sformatf("post-reset bit%0d", k), bitlog[k], pat[k % 4]);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            s_valid = ($urandom_range(0, 3) == 0);
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            if (i % 500 == 0) mute = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
